// File: rtl/pwm_peripheral.sv
// pwm_peripheral: 16-pin registered output stage with a shared 8-bit PWM.
// Each pin is forced low, held high, or driven by the common PWM waveform.
// Optional macro PWM_DUTY_SHADOW_EN: the duty value is captured only on the
// last cycle of a PWM period so a new duty never truncates or extends a pulse.
module pwm_peripheral #(
  parameter int unsigned CLK_DIV = 13
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  en_reg_out_7_0,
  input  logic [7:0]  en_reg_out_15_8,
  input  logic [7:0]  en_reg_pwm_7_0,
  input  logic [7:0]  en_reg_pwm_15_8,
  input  logic [7:0]  pwm_duty_cycle,
  output logic [15:0] out,
  output logic        period_start
);

  localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);

  logic [15:0] div_cnt_q, div_cnt_d;
  logic [7:0]  pwm_cnt_q, pwm_cnt_d;
  logic [7:0]  duty_q, duty_d;
  logic [15:0] out_q, out_d;
  logic        period_start_q, period_start_d;

  logic        step;
  logic        pwm_sig;
  logic [15:0] en_out;
  logic [15:0] en_pwm;

  assign en_out = {en_reg_out_15_8, en_reg_out_7_0};
  assign en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};

  // Prescaler, PWM counter, duty capture, compare and per-pin select.
  always_comb begin
    step      = (div_cnt_q == DIV_LAST);
    div_cnt_d = step ? '0 : div_cnt_q + 16'd1;
    pwm_cnt_d = step ? pwm_cnt_q + 8'd1 : pwm_cnt_q;

`ifdef PWM_DUTY_SHADOW_EN
    duty_d = (step && (pwm_cnt_q == 8'hFF)) ? pwm_duty_cycle : duty_q;
`else
    duty_d = pwm_duty_cycle;
`endif

    pwm_sig = (duty_q == 8'hFF) ? 1'b1 : (pwm_cnt_q < duty_q);

    // Output enable low wins; otherwise PWM select picks waveform vs. constant high.
    out_d = en_out & (~en_pwm | {16{pwm_sig}});

    period_start_d = (div_cnt_q == '0) && (pwm_cnt_q == '0);
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt_q      <= '0;
      pwm_cnt_q      <= '0;
      duty_q         <= '0;
      out_q          <= '0;
      period_start_q <= 1'b0;
    end else begin
      div_cnt_q      <= div_cnt_d;
      pwm_cnt_q      <= pwm_cnt_d;
      duty_q         <= duty_d;
      out_q          <= out_d;
      period_start_q <= period_start_d;
    end
  end

  assign out          = out_q;
  assign period_start = period_start_q;

endmodule

// File: tb/tb_pwm_peripheral.sv
// tb_pwm_peripheral: scoreboard of per-cycle expected pin/period_start values
// from a time-based reference, plus directed per-period high-time measurements.
module tb_pwm_peripheral;

  localparam int CDIV = 13;
  localparam int P    = CDIV * 256;

  logic        clk;
  logic        rst;
  logic [7:0]  en_reg_out_7_0, en_reg_out_15_8;
  logic [7:0]  en_reg_pwm_7_0, en_reg_pwm_15_8;
  logic [7:0]  pwm_duty_cycle;
  logic [15:0] out;
  logic        period_start;

  int checks   = 0;
  int failures = 0;

  pwm_peripheral #(.CLK_DIV(CDIV)) dut (
    .clk             (clk),
    .rst             (rst),
    .en_reg_out_7_0  (en_reg_out_7_0),
    .en_reg_out_15_8 (en_reg_out_15_8),
    .en_reg_pwm_7_0  (en_reg_pwm_7_0),
    .en_reg_pwm_15_8 (en_reg_pwm_15_8),
    .pwm_duty_cycle  (pwm_duty_cycle),
    .out             (out),
    .period_start    (period_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: expected values derived from cycles elapsed since reset release.
  typedef struct packed {
    logic [15:0] o;
    logic        ps;
  } exp_t;

  exp_t        sb_q[$];
  int          k = 0;
  logic [7:0]  duty_prev = '0;
  logic [7:0]  duty_sh = '0;
  logic [7:0]  m_cnt, m_duty;
  logic        m_sig;
  logic [15:0] m_en_out, m_en_pwm;
  exp_t        m_e, c_e;

  always @(posedge clk) begin
    if (rst) begin
      k         = 0;
      duty_prev = '0;
      duty_sh   = '0;
    end else begin
      m_cnt = 8'((k / CDIV) % 256);
`ifdef PWM_DUTY_SHADOW_EN
      m_duty = duty_sh;
      if (k % P == P - 1) duty_sh = pwm_duty_cycle;
`else
      m_duty    = duty_prev;
      duty_prev = pwm_duty_cycle;
`endif
      m_sig    = (m_duty == 8'hFF) ? 1'b1 : (m_cnt < m_duty);
      m_en_out = {en_reg_out_15_8, en_reg_out_7_0};
      m_en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};
      for (int i = 0; i < 16; i++)
        m_e.o[i] = m_en_out[i] ? (m_en_pwm[i] ? m_sig : 1'b1) : 1'b0;
      m_e.ps = (k % P == 0);
      sb_q.push_back(m_e);
      k++;
    end
  end

  // Scoreboard checker: compare DUT outputs mid-cycle.
  always @(negedge clk) begin
    if (rst) begin
      sb_q.delete();
      check("rst_out", 32'(out), 32'h0);
      check("rst_ps", 32'(period_start), 32'h0);
    end else if (sb_q.size() > 0) begin
      c_e = sb_q.pop_front();
      check("sb_out", 32'(out), 32'(c_e.o));
      check("sb_ps", 32'(period_start), 32'(c_e.ps));
    end
  end

  task automatic set_cfg(input logic [15:0] eo, input logic [15:0] ep, input logic [7:0] d);
    {en_reg_out_15_8, en_reg_out_7_0} = eo;
    {en_reg_pwm_15_8, en_reg_pwm_7_0} = ep;
    pwm_duty_cycle = d;
  endtask

  task automatic wait_ps(input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (period_start !== 1'b1 && n < 2 * P + 16);
    check(tag, 32'(period_start), 32'h1);
  endtask

  task automatic measure(input int pin, input int nper, output int high, output int len);
    int seen = 0;
    high = 0;
    len  = 0;
    wait_ps("ps_found");
    while (seen < nper && len < nper * P + 16) begin
      if (out[pin] === 1'b1) high++;
      len++;
      @(negedge clk);
      if (period_start === 1'b1) seen++;
    end
  endtask

  int hi, ln, exp_first;

  initial begin
    rst = 1'b1;
    set_cfg(16'hFFFF, 16'h0000, 8'h80);
    repeat (3) @(negedge clk);
    check("reset_out", 32'(out), 32'h0);
    check("reset_ps", 32'(period_start), 32'h0);
    rst = 1'b0;

    // First edge after release: period_start and constant-high pins.
    @(negedge clk);
    check("first_ps", 32'(period_start), 32'h1);
    check("first_out", 32'(out), 32'hFFFF);

    // All pins constant high; period length.
    measure(3, 1, hi, ln);
    check("t1_len", 32'(ln), 32'(P));
    check("t1_high", 32'(hi), 32'(P));

    // Pin 0 PWM at 50 %.
    set_cfg(16'h0001, 16'h0001, 8'h80);
    measure(0, 1, hi, ln);
    check("t2_high", 32'(hi), 32'(128 * CDIV));
    check("t2_low", 32'(ln - hi), 32'(128 * CDIV));

    // Duty extremes on all PWM pins.
    set_cfg(16'hFFFF, 16'hFFFF, 8'h00);
    measure(5, 1, hi, ln);
    check("t3_d00_high", 32'(hi), 32'h0);
    set_cfg(16'hFFFF, 16'hFFFF, 8'hFF);
    measure(5, 1, hi, ln);
    check("t3_dFF_high", 32'(hi), 32'(P));

    // Output enable off overrides PWM select on pin 15.
    set_cfg(16'h7FFF, 16'hFFFF, 8'h40);
    measure(15, 2, hi, ln);
    check("t4_pin15_high", 32'(hi), 32'h0);
    check("t4_len", 32'(ln), 32'(2 * P));

    // Duty change mid-period at count 0x10.
    set_cfg(16'h0001, 16'h0001, 8'h20);
    wait_ps("t5_sync");
    wait_ps("t5_start");
    hi = 0;
    for (int j = 0; j < P; j++) begin
      if (out[0] === 1'b1) hi++;
      if (j == 16 * CDIV) pwm_duty_cycle = 8'hC0;
      @(negedge clk);
    end
`ifdef PWM_DUTY_SHADOW_EN
    exp_first = 32 * CDIV;
`else
    exp_first = 192 * CDIV;
`endif
    check("t5_cur_high", 32'(hi), 32'(exp_first));
    check("t5_boundary_ps", 32'(period_start), 32'h1);
    hi = 0;
    for (int j = 0; j < P; j++) begin
      if (out[0] === 1'b1) hi++;
      @(negedge clk);
    end
    check("t5_next_high", 32'(hi), 32'(192 * CDIV));

    // Asynchronous reset mid-period at count 0x50.
    set_cfg(16'hFFFF, 16'h0000, 8'h80);
    wait_ps("t6_start");
    repeat (80 * CDIV) @(negedge clk);
    check("t6_pre_out", 32'(out), 32'hFFFF);
    #2 rst = 1'b1;
    #1;
    check("t6_async_out", 32'(out), 32'h0);
    check("t6_async_ps", 32'(period_start), 32'h0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("t6_restart_ps", 32'(period_start), 32'h1);
    check("t6_restart_out", 32'(out), 32'hFFFF);
    set_cfg(16'h0001, 16'h0001, 8'h80);
    measure(0, 1, hi, ln);
    check("t6_len", 32'(ln), 32'(P));
    check("t6_high", 32'(hi), 32'(128 * CDIV));

    repeat (4) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
